// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states and
// the alignment rule used to decide whether an op may touch memory at all.
package mem_access_stage_pkg;

  // Access size encoding shared by MemRead and MemWrite.
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  typedef enum logic {
    MA_IDLE   = 1'b0,
    MA_ACCESS = 1'b1
  } ma_state_e;

  // Halves need an even address, words need a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension
// for loads. Purely combinational; little-endian, lane 0 = bits [7:0].
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        is_unsigned,
  output logic [3:0]  be,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_sx;
  logic signed [31:0] half_sx;

  // Pick the addressed lane and build both extensions of it.
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    byte_s   = byte_sel;
    half_s   = half_sel;
    byte_sx  = 32'(byte_s);
    half_sx  = 32'(half_s);
  end

  // Size-dependent byte enables, replicated write data and load result.
  always_comb begin
    be      = 4'b1111;
    wdata_o = wdata;
    rdata_o = rdata;
    case (size)
      SZ_BYTE: begin
        be      = 4'b0001 << addr_lo;
        wdata_o = {4{wdata[7:0]}};
        rdata_o = is_unsigned ? {24'h000000, byte_sel} : $unsigned(byte_sx);
      end
      SZ_HALF: begin
        be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata[15:0]}};
        rdata_o = is_unsigned ? {16'h0000, half_sel} : $unsigned(half_sx);
      end
      default: begin
        be      = 4'b1111;
        wdata_o = wdata;
        rdata_o = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage plus MEM/WB register. Non-memory (and misaligned) ops retire
// one cycle after presentation; aligned loads/stores are captured, run a
// request/ready handshake with data memory, and retire on the ready edge.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int AW = 32
)
(
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          RegWrite,
  input  logic [1:0]    MemRead,
  input  logic [1:0]    MemWrite,
  input  logic          LoadUnsigned,
  input  logic [63:0]   ALURes,
  input  logic [31:0]   Data2,
  input  logic [4:0]    DST,
  output logic          Stall,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [3:0]    MemBe,
  output logic [31:0]   MemWData,
  input  logic [31:0]   MemRData,
  input  logic          MemReady,
  output logic          RegWriteO,
  output logic [4:0]    DSTO,
  output logic [31:0]   WBDataO,
  output logic          WBValidO,
  output logic          AlignErrO
);

  ma_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          we_q, we_d;
  logic [31:0]   data2_q, data2_d;
  logic [4:0]    dst_q, dst_d;
  logic          rw_q, rw_d;
  logic          uns_q, uns_d;

  logic          regwrite_o_q, regwrite_o_d;
  logic [4:0]    dst_o_q, dst_o_d;
  logic [31:0]   wbdata_o_q, wbdata_o_d;
  logic          wbvalid_o_q, wbvalid_o_d;
  logic          alignerr_o_q, alignerr_o_d;

  logic [1:0]    in_size;
  logic          in_store;
  logic          in_mem;
  logic          in_mis;
  logic          in_go;
  logic          access;

  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   lane_rdata;

  logic          unused_alures_hi;
  assign unused_alures_hi = ^ALURes[63:32];

  // Classify the incoming op; a store overrides any simultaneous load.
  always_comb begin
    in_store = (MemWrite != SZ_NONE);
    in_size  = in_store ? MemWrite : MemRead;
    in_mem   = (in_size != SZ_NONE);
    in_mis   = in_mem && is_misaligned(in_size, ALURes[1:0]);
    in_go    = in_mem && !in_mis;
    access   = (state_q == MA_ACCESS);
  end

  mem_lane_align u_lane_align (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .wdata       (data2_q),
    .rdata       (MemRData),
    .is_unsigned (uns_q),
    .be          (lane_be),
    .wdata_o     (lane_wdata),
    .rdata_o     (lane_rdata)
  );

  // Upstream holds while an aligned op is being captured or memory is busy.
  always_comb begin
    Stall = (!access && in_go) || (access && !MemReady);
  end

  // Request fields are decoded from the FSM state and the captured op only,
  // so they stay stable for the whole access and drop to zero outside it.
  always_comb begin
    MemReq   = access;
    MemWe    = access && we_q;
    MemAddr  = access ? {addr_q[AW-1:2], 2'b00} : '0;
    MemBe    = access ? (we_q ? lane_be : 4'b1111) : 4'b0000;
    MemWData = (access && we_q) ? lane_wdata : 32'h0;
  end

  // Next-state and write-back logic; anything that does not retire is a bubble.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    data2_d      = data2_q;
    dst_d        = dst_q;
    rw_d         = rw_q;
    uns_d        = uns_q;
    regwrite_o_d = 1'b0;
    dst_o_d      = dst_o_q;
    wbdata_o_d   = wbdata_o_q;
    wbvalid_o_d  = 1'b0;
    alignerr_o_d = 1'b0;
    case (state_q)
      MA_IDLE: begin
        if (in_go) begin
          state_d = MA_ACCESS;
          addr_d  = ALURes[AW-1:0];
          size_d  = in_size;
          we_d    = in_store;
          data2_d = Data2;
          dst_d   = DST;
          rw_d    = RegWrite;
          uns_d   = LoadUnsigned;
        end else begin
          wbvalid_o_d  = 1'b1;
          regwrite_o_d = RegWrite && !in_mis;
          dst_o_d      = DST;
          wbdata_o_d   = ALURes[31:0];
          alignerr_o_d = in_mis;
        end
      end
      MA_ACCESS: begin
        if (MemReady) begin
          state_d      = MA_IDLE;
          wbvalid_o_d  = 1'b1;
          regwrite_o_d = rw_q && !we_q;
          dst_o_d      = dst_q;
          wbdata_o_d   = we_q ? 32'h0 : lane_rdata;
        end
      end
      default: state_d = MA_IDLE;
    endcase
  end

  // State and MEM/WB register; reset abandons any access in flight.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q      <= MA_IDLE;
      addr_q       <= '0;
      size_q       <= SZ_NONE;
      we_q         <= 1'b0;
      data2_q      <= 32'h0;
      dst_q        <= 5'd0;
      rw_q         <= 1'b0;
      uns_q        <= 1'b0;
      regwrite_o_q <= 1'b0;
      dst_o_q      <= 5'd0;
      wbdata_o_q   <= 32'h0;
      wbvalid_o_q  <= 1'b0;
      alignerr_o_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      we_q         <= we_d;
      data2_q      <= data2_d;
      dst_q        <= dst_d;
      rw_q         <= rw_d;
      uns_q        <= uns_d;
      regwrite_o_q <= regwrite_o_d;
      dst_o_q      <= dst_o_d;
      wbdata_o_q   <= wbdata_o_d;
      wbvalid_o_q  <= wbvalid_o_d;
      alignerr_o_q <= alignerr_o_d;
    end
  end

  assign RegWriteO = regwrite_o_q;
  assign DSTO      = dst_o_q;
  assign WBDataO   = wbdata_o_q;
  assign WBValidO  = wbvalid_o_q;
  assign AlignErrO = alignerr_o_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues directed and random
// ops, a reference model pushes expected requests and retirements, and an
// independent monitor pops and compares whenever the DUT presents them.
module tb_mem_access_stage;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        RegWrite;
  logic [1:0]  MemRead;
  logic [1:0]  MemWrite;
  logic        LoadUnsigned;
  logic [63:0] ALURes;
  logic [31:0] Data2;
  logic [4:0]  DST;
  logic        Stall;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [3:0]  MemBe;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemReady;
  logic        RegWriteO;
  logic [4:0]  DSTO;
  logic [31:0] WBDataO;
  logic        WBValidO;
  logic        AlignErrO;

  always #5 Clk = ~Clk;

  mem_access_stage #(.AW(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .LoadUnsigned(LoadUnsigned), .ALURes(ALURes),
    .Data2(Data2), .DST(DST), .Stall(Stall), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemBe(MemBe), .MemWData(MemWData),
    .MemRData(MemRData), .MemReady(MemReady), .RegWriteO(RegWriteO),
    .DSTO(DSTO), .WBDataO(WBDataO), .WBValidO(WBValidO), .AlignErrO(AlignErrO)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  dst;
    logic [31:0] data;
    logic        aerr;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference behaviour from the size/alignment/lane rules, plain arithmetic.
  function automatic void model(input logic rw, input logic [1:0] mr, input logic [1:0] mw,
                                input logic lu, input logic [31:0] a, input logic [31:0] d2,
                                input logic [4:0] dst, input logic [31:0] rd,
                                output bit go, output wb_t w, output req_t r);
    int       size;
    int       off;
    bit       store;
    bit       mis;
    logic [31:0] v;
    store = (mw != 0);
    size  = store ? int'(mw) : int'(mr);
    off   = int'(a % 4);
    mis   = (size == 2 && (off % 2) == 1) || (size == 1 && off != 0);
    go    = (size != 0) && !mis;
    r     = '{32'h0, 1'b0, 4'h0, 32'h0};
    if (!go) begin
      w = '{rw && !mis, dst, a, mis};
    end else begin
      r.addr = a - 32'(off);
      r.we   = store;
      if (store) begin
        if (size == 3) begin
          r.be = 4'(1 << off);   r.wdata = (d2 & 32'hFF) * 32'h01010101;
        end else if (size == 2) begin
          r.be = (off >= 2) ? 4'hC : 4'h3;  r.wdata = (d2 & 32'hFFFF) * 32'h00010001;
        end else begin
          r.be = 4'hF;  r.wdata = d2;
        end
        w = '{1'b0, dst, 32'h0, 1'b0};
      end else begin
        r.be = 4'hF;
        if (size == 3) begin
          v = (rd >> (8 * off)) & 32'hFF;
          if (!lu && v >= 128) v = v + 32'hFFFFFF00;
        end else if (size == 2) begin
          v = (rd >> (16 * (off / 2))) & 32'hFFFF;
          if (!lu && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
          v = rd;
        end
        w = '{rw, dst, v, 1'b0};
      end
    end
  endfunction

  // Present one op at a falling edge; for an aligned memory op answer with
  // MemReady in the k-th ACCESS cycle. Returns at a falling edge.
  task automatic run_txn(input logic rw, input logic [1:0] mr, input logic [1:0] mw,
                         input logic lu, input logic [63:0] alu, input logic [31:0] d2,
                         input logic [4:0] dst, input logic [31:0] rd, input int k);
    bit   go;
    wb_t  w;
    req_t r;
    model(rw, mr, mw, lu, alu[31:0], d2, dst, rd, go, w, r);
    RegWrite = rw; MemRead = mr; MemWrite = mw; LoadUnsigned = lu;
    ALURes = alu; Data2 = d2; DST = dst;
    MemReady = 1'($urandom % 2);
    MemRData = $urandom;
    wb_q.push_back(w);
    if (go) req_q.push_back(r);
    #1 chk("stall_present", 32'(Stall), 32'(go));
    @(negedge Clk);
    if (go) begin
      for (int i = 1; i <= k; i++) begin
        MemReady = (i == k);
        MemRData = (i == k) ? rd : $urandom;
        #1 chk("stall_wait", 32'(Stall), 32'(i != k));
        @(negedge Clk);
      end
    end
    MemReady = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_memreq"},   32'(MemReq), 32'h0);
    chk({tag, "_memwe"},    32'(MemWe), 32'h0);
    chk({tag, "_memaddr"},  MemAddr, 32'h0);
    chk({tag, "_membe"},    32'(MemBe), 32'h0);
    chk({tag, "_memwdata"}, MemWData, 32'h0);
    chk({tag, "_regwrite"}, 32'(RegWriteO), 32'h0);
    chk({tag, "_dsto"},     32'(DSTO), 32'h0);
    chk({tag, "_wbdata"},   WBDataO, 32'h0);
    chk({tag, "_wbvalid"},  32'(WBValidO), 32'h0);
    chk({tag, "_alignerr"}, 32'(AlignErrO), 32'h0);
  endtask

  // Monitor: compares requests and retirements against the scoreboard.
  initial begin : monitor
    req_t er;
    wb_t  ew;
    forever begin
      @(negedge Clk);
      #2;
      if (MemReq) begin
        if (req_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_req: MemReq=1 addr=0x%08h, expected no request", MemAddr);
        end else begin
          er = req_q[0];
          chk("req_addr", MemAddr, er.addr);
          chk("req_we", 32'(MemWe), 32'(er.we));
          chk("req_be", 32'(MemBe), 32'(er.be));
          if (er.we) chk("req_wdata", MemWData, er.wdata);
          if (MemReady) void'(req_q.pop_front());
        end
      end
      if (WBValidO) begin
        if (wb_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_retire: WBValidO=1 data=0x%08h, expected no retire", WBDataO);
        end else begin
          ew = wb_q.pop_front();
          chk("wb_regwrite", 32'(RegWriteO), 32'(ew.rw));
          chk("wb_dst", 32'(DSTO), 32'(ew.dst));
          chk("wb_data", WBDataO, ew.data);
          chk("wb_alignerr", 32'(AlignErrO), 32'(ew.aerr));
        end
      end else begin
        chk("bubble_regwrite", 32'(RegWriteO), 32'h0);
      end
    end
  end

  // Driver: reset, directed cases, reset mid-access, then random traffic.
  initial begin : driver
    logic [1:0]  mr, mw;
    logic [31:0] a;
    Rst_n = 1'b0; RegWrite = 1'b0; MemRead = 2'b00; MemWrite = 2'b00;
    LoadUnsigned = 1'b0; ALURes = 64'h0; Data2 = 32'h0; DST = 5'd0;
    MemRData = 32'h0; MemReady = 1'b0;
    repeat (2) @(negedge Clk);
    #1 chk_all_zero("reset");
    @(negedge Clk);
    Rst_n = 1'b1;

    run_txn(1'b1, 2'b00, 2'b00, 1'b0, 64'h1234, 32'h0, 5'd5, 32'h0, 1);
    run_txn(1'b1, 2'b11, 2'b00, 1'b0, 64'h103, 32'h0, 5'd9, 32'h80FF_0000, 1);
    run_txn(1'b1, 2'b00, 2'b10, 1'b0, 64'h202, 32'hABCD_1234, 5'd4, 32'h0, 3);
    run_txn(1'b1, 2'b01, 2'b00, 1'b0, 64'h006, 32'h0, 5'd6, 32'h0, 1);
    run_txn(1'b1, 2'b10, 2'b00, 1'b1, 64'h402, 32'h0, 5'd10, 32'h8001_0000, 2);
    run_txn(1'b1, 2'b00, 2'b01, 1'b0, 64'h404, 32'hCAFE_F00D, 5'd11, 32'h0, 1);
    run_txn(1'b1, 2'b01, 2'b11, 1'b0, 64'h9_0000_0511, 32'h0000_00A5, 5'd12, 32'h0, 2);
    run_txn(1'b1, 2'b10, 2'b00, 1'b0, 64'h0A01, 32'h0, 5'd13, 32'h0, 1);

    // Abandon an access with reset, then pulse a stale MemReady in IDLE.
    RegWrite = 1'b1; MemRead = 2'b01; MemWrite = 2'b00; ALURes = 64'h800; DST = 5'd7;
    MemReady = 1'b0;
    req_q.push_back('{32'h800, 1'b0, 4'hF, 32'h0});
    #1 chk("rst_stall_capture", 32'(Stall), 32'h1);
    @(negedge Clk);
    #1 chk("rst_memreq_before", 32'(MemReq), 32'h1);
    Rst_n = 1'b0; RegWrite = 1'b0; MemRead = 2'b00; ALURes = 64'h55; DST = 5'd3;
    @(negedge Clk);
    #1 chk_all_zero("midrst");
    req_q.delete();
    Rst_n = 1'b1;
    MemReady = 1'b1;
    wb_q.push_back('{1'b0, 5'd3, 32'h55, 1'b0});
    @(negedge Clk);
    MemReady = 1'b0;

    for (int n = 0; n < 200; n++) begin
      mr = 2'($urandom % 4);
      mw = ($urandom % 3 == 0) ? 2'($urandom % 4) : 2'b00;
      if ($urandom % 4 == 0) begin mr = 2'b00; mw = 2'b00; end
      a = $urandom;
      run_txn(1'($urandom % 2), mr, mw, 1'($urandom % 2), {$urandom, a}, $urandom,
              5'($urandom % 32), $urandom, 1 + int'($urandom % 4));
    end

    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    #3;
    chk("drain_wb_queue", 32'(wb_q.size()), 32'h0);
    chk("drain_req_queue", 32'(req_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage and MEM/WB pipeline register. It sits downstream of the EX/MEM register and drives the register-file write-back. For load and store operations it runs a request/ready handshake with data memory, steers store bytes and extracts load bytes. It holds the pipeline with `Stall` until the access completes, and passes non-memory instructions to write-back with one cycle of latency.

## Interface
Parameters:
- `AW`, 32: data-memory byte-address width.

Ports:
- `Clk`  in  1: clock; all state changes on the rising edge.
- `Rst_n`  in  1: synchronous, active-low reset.
- `RegWrite`  in  1: instruction writes the register file.
- `MemRead`  in  2: load size. 00 none, 01 word, 10 half, 11 byte.
- `MemWrite`  in  2: store size; same encoding as `MemRead`.
- `LoadUnsigned`  in  1: 1 zero-extends sub-word loads, 0 sign-extends them.
- `ALURes`  in  64: bits [AW-1:0] are the effective address. Bits [31:0] are the non-load write-back value.
- `Data2`  in  32: store data.
- `DST`  in  5: destination register.
- `Stall`  out  1: holds the EX/MEM register and all earlier stages.
- `MemReq`  out  1: access request to data memory.
- `MemWe`  out  1: 1 for a store, 0 for a load.
- `MemAddr`  out  AW: word-aligned address, [1:0] = 00.
- `MemBe`  out  4: byte enables.
- `MemWData`  out  32: steered store data.
- `MemRData`  in  32: load data; valid when `MemReady` = 1.
- `MemReady`  in  1: access completes on this edge.
- `RegWriteO`  out  1: write-back enable.
- `DSTO`  out  5: write-back register.
- `WBDataO`  out  32: write-back data.
- `WBValidO`  out  1: a retiring instruction is presented this cycle.
- `AlignErrO`  out  1: the retiring instruction was misaligned.

## Operation
States are IDLE and ACCESS.

A memory op is any instruction with `MemRead` != 00 or `MemWrite` != 00. If both are nonzero, the store wins and `MemRead` is ignored.

Alignment:
- Misaligned means a half with addr[0] = 1, or a word with addr[1:0] != 00.
- A misaligned op issues no request. It retires like a non-memory op with `AlignErrO` = 1 and `RegWriteO` forced to 0.

IDLE, non-memory or misaligned op:
- Register `RegWriteO`, `DSTO`, `WBDataO` = ALURes[31:0], and `WBValidO` = 1 at the next edge.

IDLE, aligned memory op:
- Latch the address, size, `Data2`, `DST`, `RegWrite` and `LoadUnsigned`.
- Move to ACCESS.
- At the same edge, present a bubble on the outputs: `WBValidO` = 0, `RegWriteO` = 0.

ACCESS:
- `MemReq` = 1 and the request fields are driven from the latched values; they stay stable until `MemReady`.
- On an edge where `MemReady` = 1, return to IDLE, drop `MemReq`, and retire with `WBValidO` = 1.
- A load retires with `WBDataO` = extracted data and `RegWriteO` = latched `RegWrite`.
- A store retires with `RegWriteO` = 0 and `WBDataO` = 0.
- While waiting (`MemReady` = 0), outputs are a bubble.
- `MemReady` is ignored in IDLE.

Store steering (little-endian; lane 0 = bits [7:0]):
- Byte: `MemBe` = 1 << addr[1:0]; `MemWData` = {4{Data2[7:0]}}.
- Half: `MemBe` = 0011 when addr[1] = 0, 1100 when addr[1] = 1; `MemWData` = {2{Data2[15:0]}}.
- Word: `MemBe` = 1111; `MemWData` = `Data2`.
- Loads drive `MemBe` = 1111.

Load extraction:
- Byte: select lane addr[1:0].
- Half: select halfword addr[1].
- The selected value is extended to 32 bits per `LoadUnsigned`.

## Timing
- `Stall` is combinational: (IDLE and aligned memory op at the input) or (ACCESS and not `MemReady`).
- Upstream advances on the same edge that `MemReady` retires the op, so back-to-back memory ops cost one IDLE capture cycle each.
- Non-memory latency: 1 cycle.
- Memory op latency: 1 capture cycle + k cycles, where `MemReady` arrives in the k-th ACCESS cycle (k ≥ 1). Minimum 2 cycles.
- Every output is registered except `Stall`. `MemReq` and the other request outputs are decoded from state and the latched fields.
- Reset (`Rst_n` = 0 at an edge):
  - State goes to IDLE.
  - `MemReq`, `MemWe`, `MemAddr`, `MemBe`, `MemWData`, `RegWriteO`, `DSTO`, `WBDataO`, `WBValidO` and `AlignErrO` go to 0.
- Reset mid-ACCESS abandons the access. `MemReq` is 0 from the first cycle after the reset edge, and a late `MemReady` is ignored.

## Structure
- Shared package:
  - Size encodings `SZ_NONE`, `SZ_WORD`, `SZ_HALF`, `SZ_BYTE`.
  - State enum `MA_IDLE`, `MA_ACCESS`.
- One combinational sub-module, `mem_lane_align`: takes size, addr[1:0], store data, read data and the unsigned flag; returns `MemBe`, steered write data and extracted load data.

## Test plan
- Non-memory op: ALURes = 0x1234, `DST` = 5, `RegWrite` = 1 → next cycle `WBValidO` = 1, `WBDataO` = 0x1234, `RegWriteO` = 1, `Stall` never asserted.
- Signed byte load at 0x103, `MemRData` = 0x80FF_0000, `MemReady` held high → `MemAddr` = 0x100; 2 cycles after presentation `WBDataO` = 0xFFFF_FF80.
- Half store at 0x202, `Data2` = 0xABCD_1234, `MemReady` after 3 ACCESS cycles → `MemBe` = 1100, `MemWData` = 0x1234_1234, `MemWe` = 1, `Stall` high for 3 cycles, `RegWriteO` = 0 at retire.
- Word load at 0x006 → no `MemReq`, next cycle `AlignErrO` = 1, `RegWriteO` = 0, `WBValidO` = 1.
- Back-to-back unsigned half load at 0x402, `MemRData` = 0x8001_0000, then word store at 0x404 → first retire `WBDataO` = 0x0000_8001; second request has `MemBe` = 1111; no lost or duplicated `WBValidO` pulses.
- `Rst_n` low for 1 cycle during ACCESS, then `MemReady` pulsed → all outputs 0 after the reset edge, `MemReq` = 0, no retire from the abandoned access.
